// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-access stage.
//   - load/store opcode constants
//   - FSM state enum (IDLE / WAIT)
//   - access-size enum and opcode decode helpers (is_load, is_store, size)
package mem_pkg;

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    // log2 of the access size in bytes
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    function automatic logic mem_is_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic mem_is_store(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Only meaningful for memory opcodes; anything else reports a word.
    function automatic mem_size_t mem_size(input logic [7:0] op);
        mem_size_t sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational load-data lane selection and extension.
// Ports:
//   rdata_i    [DATA_W]        raw memory read data
//   lane_off_i [log2(DATA_W/8)] byte offset of the access (already size-aligned)
//   aluop_i    [8]             load opcode (selects width and signedness)
//   result_o   [DATA_W]        extended load result (0 for non-load opcodes)
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            rdata_i,
    input  logic [$clog2(DATA_W/8)-1:0]  lane_off_i,
    input  logic [7:0]                   aluop_i,
    output logic [DATA_W-1:0]            result_o
);

    logic [DATA_W-1:0] shifted;
    logic        [7:0]  lane_b;
    logic        [15:0] lane_h;
    logic signed [7:0]  lane_bs;
    logic signed [15:0] lane_hs;
    logic signed [31:0] lane_ws;

    always_comb begin
        shifted = rdata_i >> {lane_off_i, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = shifted[15:0];
        lane_bs = shifted[7:0];
        lane_hs = shifted[15:0];
        lane_ws = shifted[31:0];

        result_o = '0;
        case (aluop_i)
            OP_LB:  result_o = DATA_W'(lane_bs);
            OP_LBU: result_o = DATA_W'(lane_b);
            OP_LH:  result_o = DATA_W'(lane_hs);
            OP_LHU: result_o = DATA_W'(lane_h);
            // On a 32-bit datapath the sign extension is a no-op.
            OP_LW:  result_o = DATA_W'(lane_ws);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory-access stage with a blocking
// request/ack memory handshake.
//   Non-memory ops pass straight to the registered writeback (latency 1).
//   Loads/stores are latched, a request is held in WAIT until mem_ack_i,
//   then a single-cycle writeback pulse is produced.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   valid_i, aluop_i               execute result valid, opcode
//   write_regAddress_i/is_write_i/write_regValue_i  writeback request
//   mem_address_i, reg_operation2_value_i           address, store data
//   mem_ack_i, mem_rdata_i         memory completion, read data
//   mem_req_o/we_o/addr_o/wdata_o/be_o              memory request
//   stall_o                        upstream must hold inputs while high
//   wb_valid_o/is_write_o/write_regAddress_o/write_regValue_o  writeback
//   misalign_o                     only when MEM_ALIGN_CHECK_EN is defined
// Build option: MEM_ALIGN_CHECK_EN traps misaligned half/word accesses
// instead of silently forcing them aligned.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic [7:0]           aluop_i,
    input  logic [4:0]           write_regAddress_i,
    input  logic                 is_write_i,
    input  logic [DATA_W-1:0]    write_regValue_i,
    input  logic [ADDR_W-1:0]    mem_address_i,
    input  logic [DATA_W-1:0]    reg_operation2_value_i,
    input  logic                 mem_ack_i,
    input  logic [DATA_W-1:0]    mem_rdata_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [DATA_W-1:0]    mem_wdata_o,
    output logic [DATA_W/8-1:0]  mem_be_o,
    output logic                 stall_o,
    output logic                 wb_valid_o,
    output logic                 is_write_o,
    output logic [4:0]           write_regAddress_o,
    output logic [DATA_W-1:0]    write_regValue_o
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                 misalign_o
`endif
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    mem_state_t state_q, state_d;

    logic              in_is_mem, in_misaligned, accept_mem, idle_valid;
    logic [7:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] sdata_q;
    logic [4:0]        rd_q;
    logic              isw_q;

    mem_size_t         size_q;
    logic [OFF_W-1:0]  size_mask, off_al;
    logic [NB-1:0]     be_base, be_full;
    logic [DATA_W-1:0] wdata_rep, load_val;
    logic              in_wait, is_st_q;

    // ---- Accept: decode incoming op ----
    assign in_is_mem  = mem_is_load(aluop_i) | mem_is_store(aluop_i);
    assign idle_valid = (state_q == ST_IDLE) && valid_i;

`ifdef MEM_ALIGN_CHECK_EN
    mem_size_t in_size;
    assign in_size       = mem_size(aluop_i);
    assign in_misaligned = in_is_mem &&
        ((mem_address_i[1:0] & 2'((1 << in_size) - 1)) != 2'b00);
`else
    assign in_misaligned = 1'b0;
`endif

    assign accept_mem = idle_valid && in_is_mem && !in_misaligned;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_mem) state_d = ST_WAIT;
            ST_WAIT: if (mem_ack_i)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch: data only, qualified by accept, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept_mem) begin
            op_q    <= aluop_i;
            addr_q  <= mem_address_i;
            sdata_q <= reg_operation2_value_i;
            rd_q    <= write_regAddress_i;
            isw_q   <= is_write_i;
        end
    end

    // ---- WAIT: memory request built from latched operands ----
    always_comb begin
        size_q    = mem_size(op_q);
        size_mask = OFF_W'((1 << size_q) - 1);
        // Low address bits below the access size are dropped (forced aligned).
        off_al    = addr_q[OFF_W-1:0] & ~size_mask;
        be_base   = '0;
        wdata_rep = '0;
        case (size_q)
            SZ_BYTE: begin
                be_base   = NB'(1);
                wdata_rep = {(DATA_W/8){sdata_q[7:0]}};
            end
            SZ_HALF: begin
                be_base   = NB'(3);
                wdata_rep = {(DATA_W/16){sdata_q[15:0]}};
            end
            default: begin
                be_base   = NB'(15);
                wdata_rep = {(DATA_W/32){sdata_q[31:0]}};
            end
        endcase
        be_full = be_base << off_al;
    end

    // Outputs depend only on state and latched operands, so they are
    // stable for the whole WAIT and zero everywhere else.
    assign in_wait     = (state_q == ST_WAIT);
    assign is_st_q     = mem_is_store(op_q);
    assign mem_req_o   = in_wait;
    assign stall_o     = in_wait;
    assign mem_we_o    = in_wait & is_st_q;
    assign mem_addr_o  = in_wait ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_be_o    = in_wait ? be_full : '0;
    assign mem_wdata_o = mem_we_o ? wdata_rep : '0;

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .rdata_i    (mem_rdata_i),
        .lane_off_i (off_al),
        .aluop_i    (op_q),
        .result_o   (load_val)
    );

    // ---- Writeback: registered, single-cycle valid pulse ----
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_o         <= 1'b0;
            is_write_o         <= 1'b0;
            write_regAddress_o <= '0;
            write_regValue_o   <= '0;
        end else begin
            wb_valid_o <= 1'b0;
            is_write_o <= 1'b0;
            if (idle_valid && !in_is_mem) begin
                wb_valid_o         <= 1'b1;
                is_write_o         <= is_write_i;
                write_regAddress_o <= write_regAddress_i;
                write_regValue_o   <= write_regValue_i;
            end else if (idle_valid && in_misaligned) begin
                wb_valid_o         <= 1'b1;
                write_regAddress_o <= write_regAddress_i;
                write_regValue_o   <= '0;
            end else if (in_wait && mem_ack_i) begin
                wb_valid_o         <= 1'b1;
                write_regAddress_o <= rd_q;
                if (is_st_q) begin
                    write_regValue_o <= '0;
                end else begin
                    is_write_o       <= isw_q;
                    write_regValue_o <= load_val;
                end
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) misalign_o <= 1'b0;
        else       misalign_o <= idle_valid && in_misaligned;
    end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam logic [7:0] LB = 8'hE0, LH = 8'hE1, LW = 8'hE3, LBU = 8'hE4,
                           LHU = 8'hE5, SB = 8'hE8, SH = 8'hE9, SW = 8'hEB;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [7:0]  aluop_i;
    logic [4:0]  write_regAddress_i;
    logic        is_write_i;
    logic [31:0] write_regValue_i;
    logic [31:0] mem_address_i;
    logic [31:0] reg_operation2_value_i;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        stall_o, wb_valid_o, is_write_o;
    logic [4:0]  write_regAddress_o;
    logic [31:0] write_regValue_o;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    mem_access_stage #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .valid_i                (valid_i),
        .aluop_i                (aluop_i),
        .write_regAddress_i     (write_regAddress_i),
        .is_write_i             (is_write_i),
        .write_regValue_i       (write_regValue_i),
        .mem_address_i          (mem_address_i),
        .reg_operation2_value_i (reg_operation2_value_i),
        .mem_ack_i              (mem_ack_i),
        .mem_rdata_i            (mem_rdata_i),
        .mem_req_o              (mem_req_o),
        .mem_we_o               (mem_we_o),
        .mem_addr_o             (mem_addr_o),
        .mem_wdata_o            (mem_wdata_o),
        .mem_be_o               (mem_be_o),
        .stall_o                (stall_o),
        .wb_valid_o             (wb_valid_o),
        .is_write_o             (is_write_o),
        .write_regAddress_o     (write_regAddress_o),
        .write_regValue_o       (write_regValue_o)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misalign_o             (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---- reference model: byte-lane arithmetic on a little-endian word ----
    function automatic int op_size(input logic [7:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic bit op_load(input logic [7:0] op);
        return op == LB || op == LH || op == LW || op == LBU || op == LHU;
    endfunction

    function automatic bit op_store(input logic [7:0] op);
        return op == SB || op == SH || op == SW;
    endfunction

    function automatic int lane_off(input logic [7:0] op, input logic [31:0] addr);
        int sz;
        sz = op_size(op);
        return (int'(addr % 4) / sz) * sz;
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        longint v, span;
        int sz, off;
        sz   = op_size(op);
        off  = lane_off(op, addr);
        span = longint'(1) << (8 * sz);
        v    = longint'(rdata >> (8 * off)) % span;
        if ((op == LB || op == LH) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [7:0] op, input logic [31:0] addr);
        return 4'(((1 << op_size(op)) - 1) << lane_off(op, addr));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] data);
        logic [31:0] w;
        int sz;
        longint mask;
        sz   = op_size(op);
        mask = (longint'(1) << (8 * sz)) - 1;
        w    = '0;
        for (int i = 0; i < 4 / sz; i++)
            w = w | 32'((longint'(data) & mask) << (8 * sz * i));
        return w;
    endfunction

    // One complete transaction with all checks along the way.
    task automatic do_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rd, input logic isw,
                         input int delay, input logic [31:0] rdata,
                         input bit has_lit, input logic [31:0] lit);
        bit is_ld, is_st, mis;
        int stalls;
        is_ld = op_load(op);
        is_st = op_store(op);
        mis   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (is_ld || is_st) && (int'(addr % 4) % op_size(op) != 0);
`endif
        valid_i = 1'b1; aluop_i = op; mem_address_i = addr;
        reg_operation2_value_i = data; write_regValue_i = data;
        write_regAddress_i = rd; is_write_i = isw;
        @(posedge clk); #1;

        if (!(is_ld || is_st) || mis) begin
            valid_i = 1'b0;
            check({tag, " wb_valid"}, wb_valid_o, 1'b1);
            check({tag, " no_req"}, mem_req_o, 1'b0);
            if (mis) begin
                check({tag, " is_write"}, is_write_o, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
                check({tag, " misalign"}, misalign_o, 1'b1);
`endif
            end else begin
                check({tag, " value"}, write_regValue_o, has_lit ? lit : data);
                check({tag, " regaddr"}, write_regAddress_o, rd);
                check({tag, " is_write"}, is_write_o, isw);
            end
            @(posedge clk); #1;
            check({tag, " wb_pulse_end"}, wb_valid_o, 1'b0);
            return;
        end

        stalls = 0;
        check({tag, " req"}, mem_req_o, 1'b1);
        check({tag, " wb_idle"}, wb_valid_o, 1'b0);
        check({tag, " addr"}, mem_addr_o, addr & 32'hFFFF_FFFC);
        check({tag, " we"}, mem_we_o, is_st);
        if (is_st) begin
            check({tag, " be"}, mem_be_o, ref_be(op, addr));
            check({tag, " wdata"}, mem_wdata_o, ref_wdata(op, data));
        end
        for (int k = 0; k < delay; k++) begin
            if (stall_o) stalls++;
            @(posedge clk); #1;
        end
        if (stall_o) stalls++;
        check({tag, " req_hold"}, mem_req_o, 1'b1);
        check({tag, " addr_hold"}, mem_addr_o, addr & 32'hFFFF_FFFC);
        mem_ack_i = 1'b1; mem_rdata_i = rdata;
        @(posedge clk); #1;
        mem_ack_i = 1'b0; valid_i = 1'b0;
        check({tag, " stall_cycles"}, stalls, delay + 1);
        check({tag, " stall_drop"}, stall_o, 1'b0);
        check({tag, " req_drop"}, mem_req_o, 1'b0);
        check({tag, " wb_valid"}, wb_valid_o, 1'b1);
        check({tag, " is_write"}, is_write_o, is_ld ? isw : 1'b0);
        if (is_ld) begin
            check({tag, " value"}, write_regValue_o, ref_load(op, addr, rdata));
            check({tag, " regaddr"}, write_regAddress_o, rd);
            if (has_lit) check({tag, " lit"}, write_regValue_o, lit);
        end
        @(posedge clk); #1;
        check({tag, " wb_pulse_end"}, wb_valid_o, 1'b0);
    endtask

    initial begin
        logic [7:0] pool [10];
        logic [7:0] op;
        pool = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 8'h21, 8'hE2};

        reset = 1'b1; valid_i = 1'b0; aluop_i = '0; write_regAddress_i = '0;
        is_write_i = 1'b0; write_regValue_i = '0; mem_address_i = '0;
        reg_operation2_value_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst req", mem_req_o, 1'b0);
        check("rst stall", stall_o, 1'b0);
        check("rst wb_valid", wb_valid_o, 1'b0);
        check("rst value", write_regValue_o, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op("lw_deadbeef", LW, 32'h100, 32'h0, 5'd3, 1'b1, 3, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
        do_op("lb_sign", LB, 32'h103, 32'h0, 5'd4, 1'b1, 0, 32'h80FFFFFF, 1'b1, 32'hFFFFFF80);
        do_op("lbu_zero", LBU, 32'h103, 32'h0, 5'd4, 1'b1, 1, 32'h80FFFFFF, 1'b1, 32'h00000080);
        do_op("sh_202", SH, 32'h202, 32'h1234ABCD, 5'd9, 1'b1, 0, 32'h0, 1'b0, 32'h0);
        do_op("nonmem", 8'h20, 32'h0, 32'h5, 5'd7, 1'b1, 0, 32'h0, 1'b1, 32'h5);
        do_op("lw_101", LW, 32'h101, 32'h0, 5'd5, 1'b1, 0, 32'hCAFEF00D, 1'b0, 32'h0);
        do_op("lhu_hi", LHU, 32'h12, 32'h0, 5'd6, 1'b1, 2, 32'h8001_7FFF, 1'b1, 32'h00008001);

        // Reset while a load is waiting: request abandoned, no writeback.
        valid_i = 1'b1; aluop_i = LW; mem_address_i = 32'h300;
        write_regAddress_i = 5'd2; is_write_i = 1'b1;
        @(posedge clk); #1;
        check("rstwait req_before", mem_req_o, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; valid_i = 1'b0;
        check("rstwait req", mem_req_o, 1'b0);
        check("rstwait stall", stall_o, 1'b0);
        check("rstwait addr", mem_addr_o, 32'h0);
        check("rstwait be", mem_be_o, 4'h0);
        check("rstwait wb_valid", wb_valid_o, 1'b0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        check("late_ack req", mem_req_o, 1'b0);
        @(posedge clk); #1;
        check("late_ack wb_valid", wb_valid_o, 1'b0);

        // Ack while idle must be ignored.
        mem_ack_i = 1'b1;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        @(posedge clk); #1;
        check("idle_ack wb_valid", wb_valid_o, 1'b0);
        check("idle_ack stall", stall_o, 1'b0);

        for (int i = 0; i < 30; i++) begin
            op = pool[$urandom_range(0, 9)];
            do_op($sformatf("rnd%0d", i), op, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom, 1'b0, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter DATA_W, default 32, data path width; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, default 32, memory address width.
REQ-003 Port clk  in  1  rising-edge clock.
REQ-004 Port reset  in  1  reset, synchronous, active-high.
REQ-005 Port valid_i  in  1  execute-stage result valid.
REQ-006 Port aluop_i  in  8  operation code.
REQ-007 Port write_regAddress_i / is_write_i / write_regValue_i  in  5/1/DATA_W  writeback request from execute.
REQ-008 Port mem_address_i / reg_operation2_value_i  in  ADDR_W/DATA_W  effective address, store data.
REQ-009 Port mem_ack_i / mem_rdata_i  in  1/DATA_W  memory completion, read data.
REQ-010 Port mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o / mem_be_o  out  1/1/ADDR_W/DATA_W/DATA_W/8  memory request.
REQ-011 Port stall_o  out  1  upstream SHALL hold all inputs while high.
REQ-012 Port wb_valid_o / is_write_o / write_regAddress_o / write_regValue_o  out  1/1/5/DATA_W  registered writeback.

Function
REQ-013 Opcodes SHALL be LB 8'hE0, LH 8'hE1, LW 8'hE3, LBU 8'hE4, LHU 8'hE5, SB 8'hE8, SH 8'hE9, SW 8'hEB; any other value is a non-memory op.
REQ-014 FSM states SHALL be IDLE and WAIT only.
REQ-015 IDLE, valid_i, non-memory op: next cycle wb_valid_o=1 with writeback inputs copied; latency 1, state stays IDLE.
REQ-016 IDLE, valid_i, memory op: next cycle state=WAIT, mem_req_o=1, stall_o=1, wb_valid_o=0, op/address/data/register latched internally.
REQ-017 mem_addr_o SHALL be the latched address with the low log2(DATA_W/8) bits cleared.
REQ-018 Stores: mem_we_o=1; mem_be_o one-hot byte / aligned pair / all bytes for SB/SH/SW (SW on DATA_W=64 selects the 4-byte half given by addr[2]); store data replicated across all lanes of its size.
REQ-019 mem_req_o and all mem_* outputs SHALL remain stable in WAIT until mem_ack_i is sampled high.
REQ-020 mem_ack_i SHALL be sampled only in WAIT; ack in IDLE is ignored.
REQ-021 WAIT with mem_ack_i=1: next cycle state=IDLE, mem_req_o=0, stall_o=0, wb_valid_o=1 for one cycle.
REQ-022 Load result: lane selected by latched low address bits; LB/LH sign-extend, LBU/LHU zero-extend, LW sign-extends on DATA_W=64; is_write_o = latched is_write_i.
REQ-023 Store completion: wb_valid_o=1, is_write_o=0.
REQ-024 valid_i SHALL be ignored in WAIT; a new op is accepted earliest the cycle after return to IDLE.
REQ-025 Load latency = 1 + cycles waiting for ack; minimum 2.

Reset
REQ-026 reset high at any clock edge, including mid-WAIT: state=IDLE; every output 0; any in-flight request abandoned without writeback.
REQ-027 Memory SHALL tolerate mem_req_o dropping without ack after reset.

Configuration
REQ-028 Macro MEM_ALIGN_CHECK_EN defined: adds output misalign_o (1 bit); LH/LHU/SH with addr[0]=1, or LW/SW not aligned to 4 bytes, SHALL issue no request, stay IDLE, and produce next cycle wb_valid_o=1, is_write_o=0, misalign_o=1 for one cycle.
REQ-029 Macro undefined: no misalign_o port; misaligned address bits below the access size are ignored (access forced aligned).

Structure
REQ-030 Package mem_pkg SHALL hold opcode constants, the FSM state enum and an is_load/is_store/access-size decode function.
REQ-031 Sub-module mem_lane_align SHALL perform load lane selection and sign/zero extension combinationally.

Verification
REQ-032 LW addr 32'h100, ack after 3 WAIT cycles, rdata 32'hDEADBEEF -> stall_o high 3+1 cycles, write_regValue_o=32'hDEADBEEF, wb_valid_o pulse.
REQ-033 LB addr 32'h103, rdata 32'h80FFFFFF -> write_regValue_o=32'hFFFFFF80; LBU same -> 32'h00000080.
REQ-034 SH addr 32'h202 data 32'h1234ABCD -> mem_be_o=4'b1100, mem_wdata_o=32'hABCDABCD, mem_addr_o=32'h200, is_write_o=0.
REQ-035 Non-memory op value 32'h5 to reg 7 -> next cycle wb_valid_o=1, write_regValue_o=32'h5, no mem_req_o.
REQ-036 reset asserted in WAIT before ack -> next cycle all outputs 0; later ack ignored.
REQ-037 With MEM_ALIGN_CHECK_EN, LW addr 32'h101 -> misalign_o pulse, mem_req_o stays 0.
